// File: rtl/bcd_pkg.sv
// Shared definitions for the serial binary-to-BCD converter: FSM state
// encoding and the constant log2 helper used to size the bit counter.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

  // Smallest r with 2**r >= value; WIDTH-1 always fits in clog2(WIDTH) bits.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_ajuste_digito.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_ajuste_digito (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_conversor_serial.sv
// Iterative binary-to-BCD converter: one double-dabble step per clock,
// producing sign, packed BCD digits and an overflow flag.
module bcd_conversor_serial
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic [WIDTH-1:0]      numero,
  output logic                  ocupado,
  output logic                  valido,
  output logic                  sinal,
  output logic [4*DIGITS-1:0]   digitos,
  output logic                  overflow,
  output bcd_state_e            estado
);

  localparam int CNT_W = clog2(WIDTH);

  // Handshake: iniciar is taken only in IDLE (ocupado=0); valido pulses for
  // exactly one cycle when sinal/digitos/overflow take a new result.

  bcd_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [WIDTH-1:0]      mag_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  sinal_int_q;
  logic                  ovf_int_q;
  logic                  ocupado_q;
  logic                  valido_q;
  logic                  sinal_q;
  logic [4*DIGITS-1:0]   digitos_q;
  logic                  overflow_q;

  logic [4*DIGITS-1:0]   bcd_adj;
  logic [4*DIGITS-1:0]   bcd_shift_d;
  logic                  carry_d;
  logic                  sinal_start_d;
  logic [WIDTH-1:0]      mag_start_d;

  for (genvar k = 0; k < DIGITS; k++) begin : g_ajuste
    bcd_ajuste_digito u_ajuste (
      .din  (bcd_q[4*k +: 4]),
      .dout (bcd_adj[4*k +: 4])
    );
  end

  always_comb begin
    sinal_start_d = SIGNED & numero[WIDTH-1];
    mag_start_d   = numero;
    // Two's-complement magnitude fits in WIDTH unsigned bits, even for the most negative value.
    if (sinal_start_d) begin
      mag_start_d = ~numero + WIDTH'(1);
    end
    carry_d     = bcd_adj[4*DIGITS-1];
    bcd_shift_d = {bcd_adj[4*DIGITS-2:0], mag_q[WIDTH-1]};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      bcd_q       <= '0;
      sinal_int_q <= 1'b0;
      ovf_int_q   <= 1'b0;
      ocupado_q   <= 1'b0;
      valido_q    <= 1'b0;
      sinal_q     <= 1'b0;
      digitos_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      valido_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iniciar) begin
            sinal_int_q <= sinal_start_d;
            mag_q       <= mag_start_d;
            bcd_q       <= '0;
            ovf_int_q   <= 1'b0;
            cnt_q       <= CNT_W'(WIDTH - 1);
            ocupado_q   <= 1'b1;
            state_q     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_q <= bcd_shift_d;
          mag_q <= {mag_q[WIDTH-2:0], 1'b0};
          // A bit leaving the top digit is a multiple of 10**DIGITS.
          if (carry_d) begin
            ovf_int_q <= 1'b1;
          end
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          digitos_q  <= bcd_q;
          sinal_q    <= sinal_int_q;
          overflow_q <= ovf_int_q;
          valido_q   <= 1'b1;
          ocupado_q  <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ocupado  = ocupado_q;
  assign valido   = valido_q;
  assign sinal    = sinal_q;
  assign digitos  = digitos_q;
  assign overflow = overflow_q;
  assign estado   = state_q;

endmodule
